layer_compositor: RTL and testbench
===================================

Name: layer_compositor

Overview:
- Parametrised successor to the fixed three-layer priority mux plus hard-coded background in the VGA top level.
- Composites N_LAYERS pixel streams (board, speed meter, score, future overlays) into one pixstream for VGAcore.
- Each layer has a programmable window, enable and colour key; lower layer index has higher priority.
- Configuration is double-buffered and committed frame-synchronously, so window moves never tear mid-frame.

Parameters:
N_LAYERS, 4, number of input layers (1..8)
COLOR_W, 12, pixel width (4:4:4 RGB)
COORD_W, 10, width of h/v coordinates
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
BG_DEFAULT, 12'h333, background colour after reset

Ports:
clk_25_175  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
hreadwire  in  COORD_W  current pixel column from VGAcore
vreadwire  in  COORD_W  current pixel row from VGAcore
frame_start  in  1  one-cycle pulse at start of vertical blanking; commit strobe
layer_pix  in  N_LAYERS*COLOR_W  layer i colour at bits [i*COLOR_W +: COLOR_W]
cfg_we  in  1  config write strobe, one register per cycle
cfg_layer  in  3  target layer index
cfg_field  in  3  0 hstart, 1 hend, 2 vstart, 3 vend, 4 enable (bit0), 5 key_en (bit0), 6 key colour, 7 background (cfg_layer ignored)
cfg_data  in  COLOR_W  write data; coordinates use low COORD_W bits
cfg_pending  out  1  shadow differs from active; a commit is outstanding
pixstream  out  COLOR_W  composited pixel to VGAcore
pix_layer  out  3  winning layer index; N_LAYERS = background; 7 = blanked

Behaviour:
- Reset (reset low, asynchronous):
  - Shadow and active sets: enable=0, hstart=0, hend=H_ACTIVE, vstart=0, vend=V_ACTIVE, key_en=0, key=0, bg=BG_DEFAULT.
  - pixstream=0, pix_layer=7, cfg_pending=0, pipeline cleared.
- Config writes:
  - cfg_we writes the shadow register only; pixels never read shadow.
  - cfg_layer >= N_LAYERS with field 0..6: write ignored, cfg_pending unchanged.
  - Any accepted write sets cfg_pending the next cycle.
- Commit:
  - On a frame_start cycle, active <= shadow (values before any same-cycle write); cfg_pending <= 0.
  - cfg_we and frame_start in the same cycle: the write lands in shadow and is not committed; cfg_pending <= 1.
  - frame_start with cfg_pending=0: harmless copy.
- Pipeline, 2-cycle latency from hreadwire/vreadwire/layer_pix to pixstream/pix_layer:
  - Stage 1 registers per-layer hit[i] = enable & (hstart <= h < hend) & (vstart <= v < vend) & ~(key_en & pix == key), plus the layer pixels, background and a visible flag.
  - Stage 2 registers the result of a priority encoder: lowest i with hit[i] wins, pixstream = layer i pixel, pix_layer = i.
  - No hit: pixstream = bg, pix_layer = N_LAYERS.
  - visible = (h < H_ACTIVE) & (v < V_ACTIVE). When not visible: pixstream=0, pix_layer=7, regardless of hits.
- Window rules:
  - Comparisons are unsigned, COORD_W wide, end-exclusive.
  - start >= end gives an empty window (never hits).
  - end > H_ACTIVE/V_ACTIVE is allowed; it is clipped by the visible flag.
- Colour key: compared on the full COLOR_W; a keyed layer falls through to the next priority.
- Reset mid-frame: outputs are blank immediately; active set is the reset defaults until first commit.

Test Plan:
- Reset, then drive h=10, v=10, all layer_pix=12'hFFF -> after 2 cycles pixstream=12'h333, pix_layer=4; cfg_pending=0.
- Enable layer 1 window (100,200)x(50,80) and layer 0 window (150,300)x(0,480), no frame_start -> output unchanged and cfg_pending=1; after a frame_start pulse, h=120,v=60 -> layer 1 colour, pix_layer=1; h=160,v=60 -> layer 0, pix_layer=0; h=200,v=60 -> layer 0; h=300,v=60 -> background.
- Layer 0 key_en=1, key=12'h000, layer0 pix=12'h000, layer2 full-screen enabled with pix=12'hF00 -> pixstream=12'hF00, pix_layer=2; layer0 pix=12'h001 -> 12'h001, pix_layer=0.
- cfg_we (hend=50) and frame_start in the same cycle -> active hend unchanged, cfg_pending=1; committed on the following frame_start.
- h=640 or v=480 with all layers hitting -> pixstream=0, pix_layer=7; hstart=300, hend=300 -> layer never wins.
- Assert reset mid-line with layers active -> pixstream=0 asynchronously; after release all layers disabled, background shown.

Source files
------------

// File: rtl/layer_compositor.sv
// -----------------------------------------------------------------------------
// layer_compositor
//   Composites N_LAYERS pixel streams into one pixel stream for VGAcore.
//   Each layer has a programmable window, an enable and a colour key, and the
//   lowest layer index has the highest priority. A background colour is shown
//   where no layer hits. Configuration is written into a shadow set and copied
//   to the active set on frame_start, so window moves never tear mid-frame.
//
// Ports:
//   clk_25_175   pixel clock
//   reset        asynchronous, active-low reset
//   hreadwire    current pixel column
//   vreadwire    current pixel row
//   frame_start  one-cycle commit strobe at start of vertical blanking
//   layer_pix    layer i colour at bits [i*COLOR_W +: COLOR_W]
//   cfg_we       shadow register write strobe
//   cfg_layer    target layer index
//   cfg_field    0 hstart, 1 hend, 2 vstart, 3 vend, 4 enable, 5 key_en,
//                6 key colour, 7 background (cfg_layer ignored)
//   cfg_data     write data; coordinates use the low COORD_W bits
//   cfg_pending  shadow differs from active; a commit is outstanding
//   pixstream    composited pixel, two cycles after the coordinates
//   pix_layer    winning layer; N_LAYERS = background; 7 = blanked
// -----------------------------------------------------------------------------
module layer_compositor #(
  parameter int                 N_LAYERS   = 4,
  parameter int                 COLOR_W    = 12,
  parameter int                 COORD_W    = 10,
  parameter int                 H_ACTIVE   = 640,
  parameter int                 V_ACTIVE   = 480,
  parameter logic [COLOR_W-1:0] BG_DEFAULT = 12'h333
) (
  input  logic                          clk_25_175,
  input  logic                          reset,
  input  logic [COORD_W-1:0]            hreadwire,
  input  logic [COORD_W-1:0]            vreadwire,
  input  logic                          frame_start,
  input  logic [N_LAYERS*COLOR_W-1:0]   layer_pix,
  input  logic                          cfg_we,
  input  logic [2:0]                    cfg_layer,
  input  logic [2:0]                    cfg_field,
  input  logic [COLOR_W-1:0]            cfg_data,
  output logic                          cfg_pending,
  output logic [COLOR_W-1:0]            pixstream,
  output logic [2:0]                    pix_layer
);

  // With N_LAYERS = 8 the background code wraps to 0 in the 3-bit field;
  // callers using eight layers must rely on pixstream alone.
  localparam logic [2:0]         BG_IDX    = 3'(N_LAYERS);
  localparam logic [2:0]         BLANK_IDX = 3'd7;
  localparam logic [COORD_W-1:0] H_MAX     = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_MAX     = COORD_W'(V_ACTIVE);

  typedef struct packed {
    logic               en;
    logic               key_en;
    logic [COLOR_W-1:0] key;
    logic [COORD_W-1:0] hs;
    logic [COORD_W-1:0] he;
    logic [COORD_W-1:0] vs;
    logic [COORD_W-1:0] ve;
  } layer_cfg_t;

  localparam layer_cfg_t CFG_RESET = '{
    en:     1'b0,
    key_en: 1'b0,
    key:    {COLOR_W{1'b0}},
    hs:     {COORD_W{1'b0}},
    he:     H_MAX,
    vs:     {COORD_W{1'b0}},
    ve:     V_MAX
  };

  // Window test is end-exclusive, so start >= end never hits; a pixel equal
  // to the key colour lets the next layer show through.
  function automatic logic layer_hit(input layer_cfg_t c,
                                     input logic [COORD_W-1:0] h,
                                     input logic [COORD_W-1:0] v,
                                     input logic [COLOR_W-1:0] pix);
    return c.en & (h >= c.hs) & (h < c.he) & (v >= c.vs) & (v < c.ve)
           & ~(c.key_en & (pix == c.key));
  endfunction

  layer_cfg_t                  shadow_q [N_LAYERS];
  layer_cfg_t                  shadow_d [N_LAYERS];
  layer_cfg_t                  active_q [N_LAYERS];
  layer_cfg_t                  active_d [N_LAYERS];
  logic [COLOR_W-1:0]          bg_shadow_q, bg_shadow_d;
  logic [COLOR_W-1:0]          bg_active_q, bg_active_d;
  logic                        pending_q, pending_d;
  logic                        wr_accept_s;

  logic [N_LAYERS-1:0]         hit_q, hit_d;
  logic [N_LAYERS*COLOR_W-1:0] pix1_q, pix1_d;
  logic [COLOR_W-1:0]          bg1_q, bg1_d;
  logic                        vis_q, vis_d;
  logic [COLOR_W-1:0]          pixstream_q, pixstream_d;
  logic [2:0]                  pix_layer_q, pix_layer_d;

  // Shadow register writes; layer-indexed fields aimed past the last layer are dropped.
  always_comb begin
    shadow_d    = shadow_q;
    bg_shadow_d = bg_shadow_q;
    wr_accept_s = 1'b0;
    if (cfg_we && (cfg_field == 3'd7)) begin
      bg_shadow_d = cfg_data;
      wr_accept_s = 1'b1;
    end else if (cfg_we) begin
      for (int i = 0; i < N_LAYERS; i++) begin
        if (cfg_layer == 3'(i)) begin
          wr_accept_s = 1'b1;
          case (cfg_field)
            3'd0:    shadow_d[i].hs     = cfg_data[COORD_W-1:0];
            3'd1:    shadow_d[i].he     = cfg_data[COORD_W-1:0];
            3'd2:    shadow_d[i].vs     = cfg_data[COORD_W-1:0];
            3'd3:    shadow_d[i].ve     = cfg_data[COORD_W-1:0];
            3'd4:    shadow_d[i].en     = cfg_data[0];
            3'd5:    shadow_d[i].key_en = cfg_data[0];
            3'd6:    shadow_d[i].key    = cfg_data;
            default: shadow_d[i]        = shadow_q[i];
          endcase
        end else begin
          shadow_d[i] = shadow_q[i];
        end
      end
    end else begin
      wr_accept_s = 1'b0;
    end
  end

  // Commit copies the pre-write shadow, so a same-cycle write stays pending.
  always_comb begin
    if (frame_start) begin
      active_d    = shadow_q;
      bg_active_d = bg_shadow_q;
      pending_d   = wr_accept_s;
    end else begin
      active_d    = active_q;
      bg_active_d = bg_active_q;
      pending_d   = pending_q | wr_accept_s;
    end
  end

  // Stage 1: per-layer hit flags from the active set, plus the data stage 2 needs.
  always_comb begin
    for (int i = 0; i < N_LAYERS; i++) begin
      hit_d[i] = layer_hit(active_q[i], hreadwire, vreadwire,
                           layer_pix[i*COLOR_W +: COLOR_W]);
    end
    pix1_d = layer_pix;
    bg1_d  = bg_active_q;
    vis_d  = (hreadwire < H_MAX) & (vreadwire < V_MAX);
  end

  // Stage 2: priority select; scanning downwards lets the lowest hit index win.
  always_comb begin
    pixstream_d = {COLOR_W{1'b0}};
    pix_layer_d = BLANK_IDX;
    if (vis_q) begin
      pixstream_d = bg1_q;
      pix_layer_d = BG_IDX;
      for (int i = N_LAYERS - 1; i >= 0; i--) begin
        if (hit_q[i]) begin
          pixstream_d = pix1_q[i*COLOR_W +: COLOR_W];
          pix_layer_d = 3'(i);
        end else begin
          pixstream_d = pixstream_d;
          pix_layer_d = pix_layer_d;
        end
      end
    end else begin
      pixstream_d = {COLOR_W{1'b0}};
      pix_layer_d = BLANK_IDX;
    end
  end

  // Configuration state: shadow, active and pending flag.
  always_ff @(posedge clk_25_175 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_LAYERS; i++) begin
        shadow_q[i] <= CFG_RESET;
        active_q[i] <= CFG_RESET;
      end
      bg_shadow_q <= BG_DEFAULT;
      bg_active_q <= BG_DEFAULT;
      pending_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N_LAYERS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      bg_shadow_q <= bg_shadow_d;
      bg_active_q <= bg_active_d;
      pending_q   <= pending_d;
    end
  end

  // Pixel pipeline; reset blanks the outputs immediately.
  always_ff @(posedge clk_25_175 or negedge reset) begin
    if (!reset) begin
      hit_q       <= {N_LAYERS{1'b0}};
      pix1_q      <= {(N_LAYERS*COLOR_W){1'b0}};
      bg1_q       <= {COLOR_W{1'b0}};
      vis_q       <= 1'b0;
      pixstream_q <= {COLOR_W{1'b0}};
      pix_layer_q <= BLANK_IDX;
    end else begin
      hit_q       <= hit_d;
      pix1_q      <= pix1_d;
      bg1_q       <= bg1_d;
      vis_q       <= vis_d;
      pixstream_q <= pixstream_d;
      pix_layer_q <= pix_layer_d;
    end
  end

  assign cfg_pending = pending_q;
  assign pixstream   = pixstream_q;
  assign pix_layer   = pix_layer_q;

endmodule

// File: tb/tb_layer_compositor.sv
// -----------------------------------------------------------------------------
// tb_layer_compositor
//   Scoreboard bench for layer_compositor. The driver pushes expected pixel
//   results (due two clocks later) and expected cfg_pending values (due one
//   clock later) into queues; a monitor process pops and compares on each
//   falling edge. Expected values come from directed constants or from a
//   behavioural model of the layer rules kept in this file.
// -----------------------------------------------------------------------------
module tb_layer_compositor;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h, v;
  logic        fs;
  logic [47:0] lpix;
  logic        we;
  logic [2:0]  lay, fld;
  logic [11:0] dat;
  logic        pend;
  logic [11:0] pxo;
  logic [2:0]  plo;

  always #20 clk = ~clk;

  layer_compositor #(
    .N_LAYERS(N), .COLOR_W(12), .COORD_W(10),
    .H_ACTIVE(640), .V_ACTIVE(480), .BG_DEFAULT(12'h333)
  ) dut (
    .clk_25_175 (clk),
    .reset      (reset),
    .hreadwire  (h),
    .vreadwire  (v),
    .frame_start(fs),
    .layer_pix  (lpix),
    .cfg_we     (we),
    .cfg_layer  (lay),
    .cfg_field  (fld),
    .cfg_data   (dat),
    .cfg_pending(pend),
    .pixstream  (pxo),
    .pix_layer  (plo)
  );

  typedef struct { int due; logic [11:0] p; logic [2:0] l; } pexp_t;
  typedef struct { int due; bit pd; } dexp_t;
  typedef struct { bit en; bit ken; int key; int hs; int he; int vs; int ve; } lcfg_t;

  pexp_t pq[$];
  dexp_t dq[$];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_fail = 0;
  bit    stop_req = 1'b0;

  lcfg_t sh[N];
  lcfg_t ac[N];
  int    sh_bg, ac_bg;
  bit    m_pend;

  localparam logic [47:0] P  = {12'hDDD, 12'h00C, 12'h0B0, 12'hA00};
  localparam logic [47:0] K0 = {12'hDDD, 12'hF00, 12'h0B0, 12'h000};
  localparam logic [47:0] K1 = {12'hDDD, 12'hF00, 12'h0B0, 12'h001};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      sh[i] = '{en: 1'b0, ken: 1'b0, key: 0, hs: 0, he: 640, vs: 0, ve: 480};
      ac[i] = sh[i];
    end
    sh_bg  = 'h333;
    ac_bg  = 'h333;
    m_pend = 1'b0;
  endfunction

  // First enabled, in-window, non-keyed layer in index order wins.
  function automatic void model_px(input int hh, input int vv, input logic [47:0] pix,
                                   output logic [11:0] ep, output logic [2:0] el);
    bit found = 1'b0;
    logic [11:0] c;
    ep = 12'(ac_bg);
    el = 3'(N);
    if (hh >= 640 || vv >= 480) begin
      ep = 12'h000;
      el = 3'd7;
    end else begin
      for (int i = 0; i < N; i++) begin
        c = pix[i*12 +: 12];
        if (!found && ac[i].en && hh >= ac[i].hs && hh < ac[i].he &&
            vv >= ac[i].vs && vv < ac[i].ve && !(ac[i].ken && int'(c) == ac[i].key)) begin
          found = 1'b1;
          ep    = c;
          el    = 3'(i);
        end
      end
    end
  endfunction

  task automatic step(input int hh, input int vv, input logic [47:0] pix,
                      input bit w, input int wl, input int wf, input int wd,
                      input bit f, input bit use_x, input int xp, input int xl);
    pexp_t e;
    dexp_t d;
    logic [11:0] mp;
    logic [2:0]  ml;
    bit acc;
    h = 10'(hh); v = 10'(vv); lpix = pix;
    we = w; lay = 3'(wl); fld = 3'(wf); dat = 12'(wd); fs = f;
    model_px(hh & 1023, vv & 1023, pix, mp, ml);
    e.due = cyc + 2;
    e.p   = use_x ? 12'(xp) : mp;
    e.l   = use_x ? 3'(xl) : ml;
    pq.push_back(e);
    acc = w && (wf == 7 || wl < N);
    if (f) begin
      ac     = sh;
      ac_bg  = sh_bg;
      m_pend = 1'b0;
    end
    if (acc) begin
      case (wf)
        0: sh[wl].hs  = wd & 1023;
        1: sh[wl].he  = wd & 1023;
        2: sh[wl].vs  = wd & 1023;
        3: sh[wl].ve  = wd & 1023;
        4: sh[wl].en  = wd[0];
        5: sh[wl].ken = wd[0];
        6: sh[wl].key = wd & 'hFFF;
        default: sh_bg = wd & 'hFFF;
      endcase
      m_pend = 1'b1;
    end
    d.due = cyc + 1;
    d.pd  = m_pend;
    dq.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic px(input int hh, input int vv, input logic [47:0] pix, input int xp, input int xl);
    step(hh, vv, pix, 1'b0, 0, 0, 0, 1'b0, 1'b1, xp, xl);
  endtask

  task automatic wr(input int l, input int f, input int d);
    step(700, 0, P, 1'b1, l, f, d, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic commit();
    step(700, 0, P, 1'b0, 0, 0, 0, 1'b1, 1'b0, 0, 0);
  endtask

  function automatic logic [11:0] rpix();
    case ($urandom_range(0, 3))
      0:       return 12'h000;
      1:       return 12'h001;
      2:       return 12'hF00;
      default: return 12'($urandom);
    endcase
  endfunction

  // Monitor: blanking during reset, then scoreboard pops as entries fall due.
  initial begin : monitor
    pexp_t e;
    dexp_t d;
    forever begin
      @(negedge clk);
      if (!reset) begin
        n_vec++;
        if (pxo !== 12'h000 || plo !== 3'd7 || pend !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_blank: got pix=%h layer=%0d pending=%b, want 000/7/0", pxo, plo, pend);
        end
      end else begin
        while (pq.size() > 0 && pq[0].due <= cyc) begin
          e = pq.pop_front();
          n_vec++;
          if (pxo !== e.p || plo !== e.l) begin
            n_fail++;
            $display("FAIL pixel@%0d: got pix=%h layer=%0d, want pix=%h layer=%0d",
                     cyc, pxo, plo, e.p, e.l);
          end
        end
        while (dq.size() > 0 && dq[0].due <= cyc) begin
          d = dq.pop_front();
          n_vec++;
          if (pend !== d.pd) begin
            n_fail++;
            $display("FAIL cfg_pending@%0d: got %b, want %b", cyc, pend, d.pd);
          end
        end
        if (stop_req && (pq.size() > 0 || dq.size() > 0)) begin
          n_vec++;
          n_fail++;
          $display("FAIL drain: %0d pixel and %0d pending entries never fell due, want 0",
                   pq.size(), dq.size());
          pq.delete();
          dq.delete();
        end
      end
    end
  end

  initial begin
    reset = 1'b0; h = 10'd0; v = 10'd0; fs = 1'b0; lpix = 48'd0;
    we = 1'b0; lay = 3'd0; fld = 3'd0; dat = 12'd0;
    model_reset();
    repeat (3) @(negedge clk);
    #5 reset = 1'b1;
    @(posedge clk);
    #1;

    // Defaults: background everywhere.
    px(10, 10, {4{12'hFFF}}, 'h333, 4);

    // Two overlapping windows, shown only after commit.
    wr(1, 0, 100); wr(1, 1, 200); wr(1, 2, 50); wr(1, 3, 80); wr(1, 4, 1);
    wr(0, 0, 150); wr(0, 1, 300); wr(0, 2, 0);  wr(0, 3, 480); wr(0, 4, 1);
    px(120, 60, P, 'h333, 4);
    commit();
    px(120, 60, P, 'h0B0, 1);
    px(160, 60, P, 'hA00, 0);
    px(150, 60, P, 'hA00, 0);
    px(200, 60, P, 'hA00, 0);
    px(300, 60, P, 'h333, 4);
    px(99, 60, P, 'h333, 4);
    px(120, 80, P, 'h333, 4);

    // Colour key on layer 0 falls through to full-screen layer 2.
    wr(0, 5, 1); wr(0, 6, 'h000);
    wr(2, 0, 0); wr(2, 1, 640); wr(2, 2, 0); wr(2, 3, 480); wr(2, 4, 1);
    commit();
    px(250, 60, K0, 'hF00, 2);
    px(250, 60, K1, 'h001, 0);

    // Write coinciding with commit stays pending until the next commit.
    step(700, 0, P, 1'b1, 0, 1, 50, 1'b1, 1'b0, 0, 0);
    px(250, 60, K1, 'h001, 0);
    commit();
    px(250, 60, K1, 'hF00, 2);
    px(40, 60, K1, 'hF00, 2);

    // Blanking outside the visible area with every layer hitting.
    wr(3, 0, 0); wr(3, 1, 1023); wr(3, 2, 0); wr(3, 3, 1023); wr(3, 4, 1);
    commit();
    px(640, 60, K1, 'h000, 7);
    px(10, 479, K1, 'hF00, 2);
    px(10, 480, K1, 'h000, 7);

    // Zero-width window never wins.
    wr(3, 0, 300); wr(3, 1, 300); wr(2, 4, 0);
    commit();
    px(300, 10, P, 'h333, 4);

    // Background write ignores cfg_layer; out-of-range layer write is dropped.
    wr(5, 7, 'h123);
    commit();
    wr(6, 4, 1);
    px(300, 10, P, 'h123, 4);

    // Reset mid-line while a layer is winning.
    px(120, 60, P, 'h0B0, 1);
    px(121, 60, P, 'h0B0, 1);
    #2;
    reset = 1'b0;
    pq.delete();
    dq.delete();
    model_reset();
    we = 1'b0; fs = 1'b0;
    repeat (2) @(negedge clk);
    #5 reset = 1'b1;
    @(posedge clk);
    #1;
    px(120, 60, P, 'h333, 4);

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int wf, wd;
      logic [47:0] pix;
      pix = {rpix(), rpix(), rpix(), rpix()};
      wf  = $urandom_range(0, 7);
      case (wf)
        0, 1, 2, 3: wd = $urandom_range(0, 700);
        4, 5:       wd = $urandom_range(0, 1);
        6:          wd = int'(rpix());
        default:    wd = $urandom_range(0, 4095);
      endcase
      step($urandom_range(0, 700), $urandom_range(0, 520), pix,
           ($urandom_range(0, 2) == 0), $urandom_range(0, 7), wf, wd,
           ($urandom_range(0, 11) == 0), 1'b0, 0, 0);
    end

    we = 1'b0; fs = 1'b0;
    repeat (3) @(negedge clk);
    stop_req = 1'b1;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
